// File: rtl/queue_ram.sv
// rtl/queue_ram.sv - parametrised single-clock FIFO queue with optional flow-through and pipe modes
module queue_ram #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 79,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [WIDTH-1:0]           io_enq_bits,
  output logic                       io_deq_valid,
  input  logic                       io_deq_ready,
  output logic [WIDTH-1:0]           io_deq_bits,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic FLOW_EN = (FLOW != 0);
  localparam logic PIPE_EN = (PIPE != 0);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    enq_ptr;
  logic [PW-1:0]    deq_ptr;
  logic             maybe_full;

  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             flow_bypass;
  logic             do_enq;
  logic             do_deq;
  logic [CW-1:0]    enq_ext;
  logic [CW-1:0]    deq_ext;

  // Pointers wrap at DEPTH-1 so non-power-of-2 depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  assign io_enq_ready = ~full | (PIPE_EN & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW_EN & io_enq_valid);

  // An empty flow-through queue hands the payload straight across without touching state.
  assign flow_bypass = FLOW_EN & empty & io_deq_ready;
  assign do_enq      = io_enq_valid & io_enq_ready & ~flow_bypass;
  assign do_deq      = io_deq_valid & io_deq_ready & ~flow_bypass;

  assign io_deq_bits = (FLOW_EN & empty) ? io_enq_bits : mem[deq_ptr];

  assign enq_ext = CW'(enq_ptr);
  assign deq_ext = CW'(deq_ptr);

  // Occupancy from the pointer distance, with maybe_full resolving the equal-pointer case.
  always_comb begin
    io_count = '0;
    if (ptr_match) begin
      io_count = maybe_full ? DEPTH_C : '0;
    end else if (enq_ptr > deq_ptr) begin
      io_count = enq_ext - deq_ext;
    end else begin
      io_count = DEPTH_C - deq_ext + enq_ext;
    end
  end

  // Payload store; deliberately not reset since contents are only read behind valid.
  always_ff @(posedge clock) begin
    if (do_enq && !reset) begin
      mem[enq_ptr] <= io_enq_bits;
    end
  end

  // Pointer and full-flag update; reset discards every stored entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) begin
        enq_ptr <= ptr_inc(enq_ptr);
      end
      if (do_deq) begin
        deq_ptr <= ptr_inc(deq_ptr);
      end
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

endmodule

// File: tb/tb_queue_ram.sv
// tb/tb_queue_ram.sv - randomized scoreboard bench for queue_ram across several depth/flow/pipe builds
module tb_queue_ram;

  localparam int NI = 6;
  localparam int W  = 79;
  localparam int DEP [NI] = '{3, 3, 3, 1, 4, 4};
  localparam int FLW [NI] = '{0, 0, 1, 0, 0, 1};
  localparam int PIP [NI] = '{0, 1, 0, 1, 0, 1};

  logic         clock = 1'b0;
  logic         reset;
  logic         enq_valid [NI];
  logic         enq_ready [NI];
  logic [W-1:0] enq_bits  [NI];
  logic         deq_valid [NI];
  logic         deq_ready [NI];
  logic [W-1:0] deq_bits  [NI];
  logic [2:0]   count     [NI];

  int checks   = 0;
  int failures = 0;

  // Reference FIFO per instance: a ring of stored payloads plus head index and occupancy.
  logic [W-1:0] ring [NI][16];
  int           head [NI];
  int           cnt  [NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int D = DEP[g];
    logic [$clog2(D+1)-1:0] c;
    queue_ram #(.DEPTH(D), .WIDTH(W), .FLOW(FLW[g]), .PIPE(PIP[g])) u_dut (
      .clock        (clock),
      .reset        (reset),
      .io_enq_valid (enq_valid[g]),
      .io_enq_ready (enq_ready[g]),
      .io_enq_bits  (enq_bits[g]),
      .io_deq_valid (deq_valid[g]),
      .io_deq_ready (deq_ready[g]),
      .io_deq_bits  (deq_bits[g]),
      .io_count     (c)
    );
    assign count[g] = 3'(c);
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_all(input logic ev, input logic [W-1:0] eb, input logic dr);
    for (int i = 0; i < NI; i++) begin
      enq_valid[i] = ev;
      enq_bits[i]  = eb;
      deq_ready[i] = dr;
    end
  endtask

  // Compare every instance against the model, clock once, then advance the model.
  task automatic step();
    #1;
    for (int i = 0; i < NI; i++) begin
      logic er, dv;
      er = (cnt[i] < DEP[i]) || (PIP[i] != 0 && deq_ready[i]);
      dv = (cnt[i] > 0) || (FLW[i] != 0 && enq_valid[i]);
      check($sformatf("i%0d_enq_ready", i), 80'(enq_ready[i]), 80'(er));
      check($sformatf("i%0d_deq_valid", i), 80'(deq_valid[i]), 80'(dv));
      check($sformatf("i%0d_count", i), 80'(count[i]), 80'(cnt[i]));
      if (dv) begin
        check($sformatf("i%0d_deq_bits", i), 80'(deq_bits[i]),
              80'((cnt[i] > 0) ? ring[i][head[i]] : enq_bits[i]));
      end
    end
    @(posedge clock);
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        cnt[i]  = 0;
        head[i] = 0;
      end else begin
        logic bypass, deq, enq;
        bypass = (FLW[i] != 0) && cnt[i] == 0 && deq_ready[i];
        deq    = !bypass && cnt[i] > 0 && deq_ready[i];
        enq    = !bypass && enq_valid[i] &&
                 ((cnt[i] < DEP[i]) || (PIP[i] != 0 && deq_ready[i]));
        if (deq) begin
          head[i] = (head[i] + 1) % 16;
          cnt[i]--;
        end
        if (enq) begin
          ring[i][(head[i] + cnt[i]) % 16] = enq_bits[i];
          cnt[i]++;
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [W-1:0] nxt;
    logic [W-1:0] exp_out;
    reset = 1'b1;
    drive_all(1'b0, '0, 1'b0);
    for (int i = 0; i < NI; i++) begin
      cnt[i]  = 0;
      head[i] = 0;
    end
    @(negedge clock);
    @(negedge clock);
    step();
    reset = 1'b0;

    check("reset_count", 80'(count[0]), 80'd0);
    check("reset_enq_ready", 80'(enq_ready[0]), 80'd1);
    check("reset_deq_valid", 80'(deq_valid[0]), 80'd0);

    // Fill the depth-3 queue without draining.
    for (int v = 1; v <= 3; v++) begin
      drive_all(1'b1, W'(v), 1'b0);
      step();
      check("fill_count", 80'(count[0]), 80'(v));
    end
    drive_all(1'b0, '0, 1'b0);
    #1;
    check("full_enq_ready", 80'(enq_ready[0]), 80'd0);
    check("full_head", 80'(deq_bits[0]), 80'h1);

    // Four laps of drain-three / refill-three to exercise pointer wrap.
    nxt     = W'(4);
    exp_out = W'(1);
    for (int lap = 0; lap < 4; lap++) begin
      for (int k = 0; k < 3; k++) begin
        drive_all(1'b0, '0, 1'b1);
        #1;
        check("lap_order", 80'(deq_bits[0]), 80'(exp_out));
        exp_out = exp_out + W'(1);
        step();
      end
      for (int k = 0; k < 3; k++) begin
        drive_all(1'b1, nxt, 1'b0);
        nxt = nxt + W'(1);
        step();
      end
      check("lap_count", 80'(count[0]), 80'd3);
    end

    // Full queue offered enq and deq together: plain build drains, pipe build stays full.
    drive_all(1'b1, W'(80'h99), 1'b1);
    step();
    check("nopipe_full_count", 80'(count[0]), 80'd2);
    check("pipe_full_count", 80'(count[1]), 80'd3);
    drive_all(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("pipe_drain", 80'(deq_bits[1]), (k == 2) ? 80'h99 : 80'(14 + k));
      step();
    end

    // Flow-through from an empty queue.
    drive_all(1'b1, W'(80'h55), 1'b1);
    #1;
    check("flow_deq_valid", 80'(deq_valid[2]), 80'd1);
    check("flow_deq_bits", 80'(deq_bits[2]), 80'h55);
    step();
    check("flow_count", 80'(count[2]), 80'd0);

    // Drain, load two entries, then reset while an enqueue is offered.
    drive_all(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 2; k++) begin
      drive_all(1'b1, W'(k + 32), 1'b0);
      step();
    end
    reset = 1'b1;
    drive_all(1'b1, W'(80'h77), 1'b0);
    step();
    reset = 1'b0;
    drive_all(1'b0, '0, 1'b0);
    #1;
    check("post_reset_count", 80'(count[0]), 80'd0);
    check("post_reset_deq_valid", 80'(deq_valid[0]), 80'd0);
    check("post_reset_enq_ready", 80'(enq_ready[0]), 80'd1);
    step();

    // Random traffic on every build against the model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      reset = (($urandom % 1000) == 0);
      for (int i = 0; i < NI; i++) begin
        enq_valid[i] = ($urandom % 4) != 0;
        deq_ready[i] = ($urandom % 3) != 0;
        enq_bits[i]  = W'({$urandom, $urandom, $urandom});
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
